// File: rtl/zxuno_uart_fifo.sv
// ZXUNO register-mapped UART with TX/RX FIFOs, programmable divisor, sticky error flags and RTS.
// Register reads are combinational; TX writes to a full FIFO are dropped, RX overflow sets a sticky flag.
module zxuno_uart_fifo #(
    parameter int          CLK        = 28000000,
    parameter int          BAUD       = 115200,
    parameter int          FIFO_AW    = 4,
    parameter int          RTS_MARGIN = 2,
    parameter logic [7:0]  UARTDATA   = 8'hC6,
    parameter logic [7:0]  UARTSTAT   = 8'hC7,
    parameter logic [7:0]  UARTDIVL   = 8'hC8,
    parameter logic [7:0]  UARTDIVH   = 8'hC9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] zxuno_addr,
    input  logic       zxuno_regrd,
    input  logic       zxuno_regwr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       oe,
    output logic       uart_tx,
    input  logic       uart_rx,
    output logic       uart_rts
);

    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam logic [15:0]      RESET_DIV = 16'(CLK / BAUD - 1);
    localparam logic [FIFO_AW:0] RTS_LEVEL = (FIFO_AW+1)'(DEPTH - RTS_MARGIN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // ---------------- register bus ----------------
    logic sel_data, sel_stat, sel_divl, sel_divh;
    logic data_rd_q, stat_rd_q, data_wr_q, divl_wr_q, divh_wr_q;
    logic data_rd_ev, stat_rd_ev, data_wr_ev, divl_wr_ev, divh_wr_ev;

    assign sel_data = (zxuno_addr == UARTDATA);
    assign sel_stat = (zxuno_addr == UARTSTAT);
    assign sel_divl = (zxuno_addr == UARTDIVL);
    assign sel_divh = (zxuno_addr == UARTDIVH);

    // Strobes are levels; only the first qualified cycle acts.
    assign data_rd_ev = sel_data && zxuno_regrd && !data_rd_q;
    assign stat_rd_ev = sel_stat && zxuno_regrd && !stat_rd_q;
    assign data_wr_ev = sel_data && zxuno_regwr && !data_wr_q;
    assign divl_wr_ev = sel_divl && zxuno_regwr && !divl_wr_q;
    assign divh_wr_ev = sel_divh && zxuno_regwr && !divh_wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_rd_q <= 1'b0;
            stat_rd_q <= 1'b0;
            data_wr_q <= 1'b0;
            divl_wr_q <= 1'b0;
            divh_wr_q <= 1'b0;
        end else begin
            data_rd_q <= sel_data && zxuno_regrd;
            stat_rd_q <= sel_stat && zxuno_regrd;
            data_wr_q <= sel_data && zxuno_regwr;
            divl_wr_q <= sel_divl && zxuno_regwr;
            divh_wr_q <= sel_divh && zxuno_regwr;
        end
    end

    // ---------------- divisor ----------------
    logic [15:0] div_reg, div_eff;
    logic [7:0]  div_stage;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg   <= RESET_DIV;
            div_stage <= 8'd0;
        end else begin
            if (divl_wr_ev) div_stage <= din;
            if (divh_wr_ev) div_reg   <= {din, div_stage};
        end
    end

    assign div_eff = (div_reg < 16'd7) ? 16'd7 : div_reg;

    // ---------------- TX FIFO ----------------
    logic [7:0]       tx_mem [DEPTH];
    logic [FIFO_AW:0] tx_wp, tx_rp;
    logic             tx_empty, tx_full, tx_push, tx_pop;
    logic [7:0]       tx_head;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                      (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
    assign tx_head  = tx_mem[tx_rp[FIFO_AW-1:0]];
    assign tx_push  = data_wr_ev && (!tx_full || tx_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= din;
    end

    // ---------------- TX FSM ----------------
    logic [1:0]  tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_line, tx_idle;

    // The end of a stop bit can chain straight into the next start bit.
    assign tx_pop  = !tx_empty && ((tx_state == S_IDLE) ||
                                  (tx_state == S_STOP && tx_cnt == 16'd0));
    assign tx_idle = tx_empty && (tx_state == S_IDLE);
    assign uart_tx = tx_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
            tx_line  <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (tx_pop) begin
                        tx_state <= S_START;
                        tx_cnt   <= div_eff;
                        tx_shift <= tx_head;
                        tx_line  <= 1'b0;
                    end
                end
                S_START: begin
                    if (tx_cnt == 16'd0) begin
                        tx_state <= S_DATA;
                        tx_cnt   <= div_eff;
                        tx_bit   <= 3'd0;
                        tx_line  <= tx_shift[0];
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt <= div_eff;
                        if (tx_bit == 3'd7) begin
                            tx_state <= S_STOP;
                            tx_line  <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_line  <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (tx_cnt == 16'd0) begin
                        if (tx_pop) begin
                            tx_state <= S_START;
                            tx_cnt   <= div_eff;
                            tx_shift <= tx_head;
                            tx_line  <= 1'b0;
                        end else begin
                            tx_state <= S_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    // ---------------- RX synchroniser and FSM ----------------
    logic        rx_meta, rx_sync;
    logic [1:0]  rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_stop_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    assign rx_stop_tick = (rx_state == S_STOP) && (rx_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= S_IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    if (!rx_sync) begin
                        rx_state <= S_START;
                        rx_cnt   <= {1'b0, div_eff[15:1]};
                    end
                end
                S_START: begin
                    if (rx_cnt == 16'd0) begin
                        if (rx_sync) begin
                            rx_state <= S_IDLE;
                        end else begin
                            rx_state <= S_DATA;
                            rx_cnt   <= div_eff;
                            rx_bit   <= 3'd0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_cnt   <= div_eff;
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: begin
                    if (rx_cnt == 16'd0) rx_state <= S_IDLE;
                    else                 rx_cnt   <= rx_cnt - 16'd1;
                end
            endcase
        end
    end

    // ---------------- RX FIFO, flags, RTS ----------------
    logic [7:0]       rx_mem [DEPTH];
    logic [FIFO_AW:0] rx_wp, rx_rp, rx_level;
    logic             rx_empty, rx_full, rx_push, rx_pop;
    logic             ovr_set, fe_set, overrun, framing_err, rts_q;
    logic [7:0]       rx_head, rx_last, status;

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                      (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);
    assign rx_level = rx_wp - rx_rp;
    assign rx_head  = rx_mem[rx_rp[FIFO_AW-1:0]];
    assign rx_pop   = data_rd_ev && !rx_empty;
    assign rx_push  = rx_stop_tick && rx_sync && (!rx_full || rx_pop);
    assign ovr_set  = rx_stop_tick && rx_sync && rx_full && !rx_pop;
    assign fe_set   = rx_stop_tick && !rx_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp       <= '0;
            rx_rp       <= '0;
            rx_last     <= 8'd0;
            overrun     <= 1'b0;
            framing_err <= 1'b0;
            rts_q       <= 1'b0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop) begin
                rx_rp   <= rx_rp + 1'b1;
                rx_last <= rx_head;
            end
            // A new error in the same cycle as the status read survives the clear.
            overrun     <= ovr_set | (overrun & ~stat_rd_ev);
            framing_err <= fe_set | (framing_err & ~stat_rd_ev);
            rts_q       <= (rx_level >= RTS_LEVEL);
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_shift;
    end

    assign uart_rts = rts_q;
    assign status   = {!rx_empty, tx_full, overrun, framing_err, tx_idle, 3'b000};
    assign oe       = zxuno_regrd && (sel_data || sel_stat || sel_divl || sel_divh);

    always_comb begin
        dout = 8'hFF;
        if (zxuno_regrd) begin
            if (sel_data)      dout = rx_empty ? rx_last : rx_head;
            else if (sel_stat) dout = status;
            else if (sel_divl) dout = div_reg[7:0];
            else if (sel_divh) dout = div_reg[15:8];
        end
    end

endmodule
